// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract pipeline.
// Latency: none (declarations only).
// Backpressure: not applicable.
package addsub_pkg;

   // Operation select, encoded as {accumulate, subtract}
   typedef enum logic [1:0] {
      OP_ADD     = 2'b00,
      OP_SUB     = 2'b01,
      OP_ACC_ADD = 2'b10,
      OP_ACC_SUB = 2'b11
   } op_e;

   // Bit positions inside the 4-bit {N, Z, V, C} flag vector
   localparam int FLAG_C = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 3;
   localparam int FLAG_W = 4;

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor producing sum and {N, Z, V, C}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers and handshakes the result.
module addsub_core
   import addsub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]  x,
   input  logic [WIDTH-1:0]  y,
   input  logic              sub,
   output logic [WIDTH-1:0]  sum,
   output logic [FLAG_W-1:0] flags
);

   logic [WIDTH-1:0] y_eff;
   logic [WIDTH:0]   full;

   // Subtraction is x + ~y + 1, computed one bit wider to expose the carry-out
   assign y_eff = sub ? ~y : y;
   assign full  = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
   assign sum   = full[WIDTH-1:0];

   // Flag derivation: carry becomes borrow when subtracting (inverted carry-out);
   // overflow compares against the effective addend so one rule covers both ops
   always_comb begin
      flags         = '0;
      flags[FLAG_C] = full[WIDTH] ^ sub;
      flags[FLAG_V] = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      flags[FLAG_Z] = (sum == '0);
      flags[FLAG_N] = sum[WIDTH-1];
   end

endmodule

// File: rtl/addsub_pipe.sv
// Registered add/sub unit with accumulator, status flags and valid/ready handshakes.
// Latency: one cycle from input acceptance to out_valid; one result per cycle.
// Backpressure: in_ready drops while a result is held and out_ready is low; output stays stable.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        op,
   input  logic [WIDTH-1:0]  input_a,
   input  logic [WIDTH-1:0]  input_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  output_c,
   output logic [FLAG_W-1:0] flags
);

   op_e               op_sel;
   logic              acc_op;
   logic              sub_op;
   logic              accept;
   logic [WIDTH-1:0]  acc;
   logic [WIDTH-1:0]  acc_eff;
   logic [WIDTH-1:0]  core_x;
   logic [WIDTH-1:0]  core_y;
   logic [WIDTH-1:0]  core_sum;
   logic [FLAG_W-1:0] core_flags;

   assign op_sel = op_e'(op);
   assign acc_op = (op_sel == OP_ACC_ADD) || (op_sel == OP_ACC_SUB);
   assign sub_op = (op_sel == OP_SUB)     || (op_sel == OP_ACC_SUB);

   // A slot is free when nothing is held or the held result leaves this cycle
   assign in_ready = en && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Clear takes effect on the operand in the same cycle, so clr + ACC op starts from zero
   assign acc_eff = clr ? '0 : acc;
   assign core_x  = acc_op ? acc_eff : input_a;
   assign core_y  = acc_op ? input_a : input_b;

   addsub_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .x     (core_x),
      .y     (core_y),
      .sub   (sub_op),
      .sum   (core_sum),
      .flags (core_flags)
   );

   // Accumulator: accepted ACC ops load the result; otherwise clr zeroes it, independent of en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (accept && acc_op) begin
         acc <= core_sum;
      end else if (clr) begin
         acc <= '0;
      end
   end

   // Output register: load on acceptance, drop valid on a drain-only handshake, hold data otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         output_c  <= '0;
         flags     <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         output_c  <= core_sum;
         flags     <= core_flags;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=4): directed cases plus randomized traffic.
// Expected results come from an integer-arithmetic reference model or constant tables.
// A monitor pops the scoreboard on every output handshake.
module tb_addsub_pipe;

   localparam int W = 4;

   typedef struct {
      logic [3:0] c;
      logic [3:0] f;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         clr;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic [W-1:0] input_a;
   logic [W-1:0] input_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] output_c;
   logic [3:0]   flags;

   int   n_cmp;
   int   n_bad;
   int   acc_m;
   bit   rand_bp;
   exp_t sb[$];

   addsub_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .input_a   (input_a),
      .input_b   (input_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .output_c  (output_c),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on unsigned and signed views
   function automatic void model(input logic [1:0] o, input int a, input int b, input int acc_in,
                                 input bit clr_v, output int res, output logic [3:0] f,
                                 output int acc_out);
      int  acc_e;
      int  x;
      int  y;
      int  sx;
      int  sy;
      int  r;
      int  s;
      bit  c;
      bit  v;
      acc_e = clr_v ? 0 : acc_in;
      x  = o[1] ? acc_e : a;
      y  = o[1] ? a : b;
      sx = (x >= 8) ? x - 16 : x;
      sy = (y >= 8) ? y - 16 : y;
      if (o[0]) begin
         r = x - y;
         s = sx - sy;
         c = (x < y);
      end else begin
         r = x + y;
         s = sx + sy;
         c = (r > 15);
      end
      res = ((r % 16) + 16) % 16;
      v   = (s > 7) || (s < -8);
      f   = {res >= 8, res == 0, v, c};
      acc_out = o[1] ? res : acc_e;
   endfunction

   // Present one transaction until accepted; push the expected result at the accepting edge
   task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                        input bit cl, input bit use_exp, input logic [3:0] ec, input logic [3:0] ef);
      int         res;
      int         nacc;
      logic [3:0] f;
      bit         done;
      exp_t       e;
      in_valid = 1'b1;
      op       = o;
      input_a  = a;
      input_b  = b;
      clr      = cl;
      done     = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            model(o, int'(a), int'(b), acc_m, cl, res, f, nacc);
            acc_m = nacc;
            e.c = use_exp ? ec : res[3:0];
            e.f = use_exp ? ef : f;
            sb.push_back(e);
            done = 1'b1;
            @(posedge clk);
            #1;
            check("latency_out_valid", 32'(out_valid), 32'd1);
         end else begin
            if (cl) acc_m = 0;
            @(posedge clk);
            #1;
         end
      end
      if (!done) check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      clr      = 1'b0;
   endtask

   // Monitor: every output handshake must match the oldest expected entry
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 32'(output_c), 32'hFFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result_c", 32'(output_c), 32'(e.c));
               check("result_flags", 32'(flags), 32'(e.f));
            end
         end
      end
   end

   // Random backpressure and enable toggling during the random phase
   initial begin
      forever begin
         @(posedge clk);
         if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
         end
      end
   end

   initial begin
      n_cmp = 0; n_bad = 0; acc_m = 0; rand_bp = 1'b0;
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b1; op = 2'b00;
      input_a = 4'd3; input_b = 4'd4; out_ready = 1'b1;

      // Reset state and en=0 blocking
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_output_c", 32'(output_c), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("en0_in_ready", 32'(in_ready), 32'd0);
         check("en0_out_valid", 32'(out_valid), 32'd0);
         check("en0_output_c", 32'(output_c), 32'd0);
      end
      @(posedge clk);
      #1 en = 1'b1; in_valid = 1'b0;

      // Add / subtract
      issue(2'b00, 4'd1, 4'd0, 1'b0, 1'b1, 4'd1,  4'b0000);
      issue(2'b00, 4'd8, 4'd4, 1'b0, 1'b1, 4'd12, 4'b1000);
      issue(2'b01, 4'd4, 4'd1, 1'b0, 1'b1, 4'd3,  4'b0000);
      issue(2'b01, 4'd1, 4'd1, 1'b0, 1'b1, 4'd0,  4'b0100);
      issue(2'b01, 4'd0, 4'd1, 1'b0, 1'b1, 4'd15, 4'b1001);
      issue(2'b00, 4'd7, 4'd1, 1'b0, 1'b1, 4'd8,  4'b1010);

      // Accumulator chain: clr then 3,5,9 -> 3,8,1; sub 2 -> 15; add leaves acc; +10 -> 9
      issue(2'b10, 4'd3,  4'd0, 1'b1, 1'b1, 4'd3,  4'b0000);
      issue(2'b10, 4'd5,  4'd0, 1'b0, 1'b1, 4'd8,  4'b1010);
      issue(2'b10, 4'd9,  4'd0, 1'b0, 1'b1, 4'd1,  4'b0011);
      issue(2'b11, 4'd2,  4'd0, 1'b0, 1'b1, 4'd15, 4'b1001);
      issue(2'b00, 4'd1,  4'd1, 1'b0, 1'b1, 4'd2,  4'b0000);
      issue(2'b10, 4'd10, 4'd0, 1'b0, 1'b1, 4'd9,  4'b1001);
      // clr with ACC_ADD 6 while acc=9, then +0 confirms acc=6
      issue(2'b10, 4'd6,  4'd0, 1'b1, 1'b1, 4'd6,  4'b0000);
      issue(2'b10, 4'd0,  4'd0, 1'b0, 1'b1, 4'd6,  4'b0000);

      // Backpressure: hold a result, stall three cycles, then release
      issue(2'b00, 4'd2, 4'd3, 1'b0, 1'b1, 4'd5, 4'b0000);
      out_ready = 1'b0;
      in_valid = 1'b1; op = 2'b00; input_a = 4'd3; input_b = 4'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_output_c", 32'(output_c), 32'd5);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      issue(2'b00, 4'd3, 4'd3, 1'b0, 1'b1, 4'd6, 4'b0000);

      // Reset while a result is pending and acc=5
      issue(2'b10, 4'd5, 4'd0, 1'b1, 1'b1, 4'd5, 4'b0000);
      out_ready = 1'b0;
      @(negedge clk);
      check("prerst_out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_output_c", 32'(output_c), 32'd0);
      sb.delete();
      acc_m = 0;
      @(posedge clk);
      #1 rst_n = 1'b1; out_ready = 1'b1;
      issue(2'b10, 4'd2, 4'd0, 1'b0, 1'b1, 4'd2, 4'b0000);

      // Randomized traffic against the reference model
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 9) == 0), 1'b0, 4'd0, 4'd0);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_bp = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1; en = 1'b1;

      // Drain and confirm nothing lost or duplicated
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("final_out_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, registered add/subtract unit with an internal accumulator, valid/ready handshakes and arithmetic status flags. Successor to the 4-bit combinational add/sub mux: same enable and add/sub selection, now generalised to WIDTH bits, extended with accumulate modes and flags, and placed behind a one-stage output register so it can sit in a streaming datapath between a producer and a consumer with backpressure.

## Interface
- WIDTH, 4: operand, result and accumulator width in bits; must be at least 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; while low, no input is accepted and the output register holds its contents.
- clr  in  1  synchronous accumulator clear.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  input can be accepted.
- op  in  2  operation: 00 ADD a+b, 01 SUB a-b, 10 ACC_ADD acc+a, 11 ACC_SUB acc-a.
- input_a  in  WIDTH  operand A.
- input_b  in  WIDTH  operand B; ignored for ACC ops.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- output_c  out  WIDTH  result.
- flags  out  4  {N, Z, V, C} for output_c.

## Operation
- The input is accepted on an edge where in_valid && in_ready.
- in_ready = en && (!out_valid || out_ready). The term is combinational and has no dependency on in_valid.
- Effective accumulator operand: accE = clr ? 0 : acc.
- Result computation:
  - ADD: a+b, carry-in 0.
  - SUB: a+~b+1.
  - ACC_ADD: accE+a.
  - ACC_SUB: accE+~a+1.
- All arithmetic is done at WIDTH+1 bits, and the result is truncated modulo 2^WIDTH.
- Flag definitions:
  - C: for add, the carry-out. For subtract, the borrow, i.e. 1 when the minuend is less than the subtrahend (unsigned).
  - V: signed overflow, meaning the operands have the same sign and the result sign differs. For subtract, the operand signs differ and the result sign differs from the minuend.
  - Z: result == 0.
  - N: result MSB.
- Accumulator update:
  - On acceptance of an ACC op, acc ← the result.
  - On acceptance of ADD or SUB, acc is unchanged, or becomes 0 if clr is high.
  - When clr is high with no acceptance, acc ← 0.
  - clr acts regardless of en.
- Output register: on acceptance, output_c/flags ← the new result/flags and out_valid ← 1.
- When out_valid && out_ready with no new acceptance, out_valid ← 0. output_c and flags hold their last values.
- en low blocks acceptance only. A pending result still drains when out_ready is high.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, output_c=0, flags=0, acc=0. in_ready then follows en.
- Latency is 1 cycle: a result accepted at edge k is valid after edge k.
- Throughput is 1 per cycle while out_ready is held high. Back-to-back ACC ops chain correctly because acc updates on the same edge as the output.
- Backpressure: when out_valid && !out_ready, in_ready=0, and output_c/flags stay stable until the handshake completes.
- Simultaneous output handshake and new acceptance: out_valid stays 1 and the data is replaced.
- Reset asserted mid-transaction discards any pending result and clears acc.

## Structure
- Package addsub_pkg holds:
  - the op_e enum: OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB.
  - flag bit index constants: FLAG_C=0, FLAG_V=1, FLAG_Z=2, FLAG_N=3.
- One combinational sub-module, addsub_core, parametrised by WIDTH:
  - inputs x, y, sub.
  - outputs sum and {N, Z, V, C}.
- The top level holds the operand muxing, the accumulator, the handshake and the output register.

## Test plan
All scenarios use WIDTH=4.
- Reset and enable: rst_n low, then release with en=0 and in_valid=1 → in_ready=0, out_valid stays 0, output_c=0.
- Add and subtract:
  - ADD 1+0 → 1, flags 0000.
  - ADD 8+4 → 12, N=1.
  - SUB 4−1 → 3.
  - SUB 1−1 → 0, Z=1.
  - SUB 0−1 → 15, C=1, N=1.
  - ADD 7+1 → 8, V=1, N=1.
  - Every result appears one cycle after its acceptance.
- Accumulator:
  - clr, then ACC_ADD with a = 3, 5, 9 back-to-back → outputs 3, 8, 1 (the last with C=1).
  - ACC_SUB with a=2 → 15, C=1.
  - ADD 1+1 between ACC ops leaves acc unchanged.
- clr with a simultaneous ACC_ADD a=6 while acc=9 → output 6, acc=6.
- Backpressure: out_ready held low for 3 cycles with in_valid high → in_ready=0 and output_c stable. Raise out_ready → the next result arrives with no loss or duplication.
- Pull rst_n low while out_valid=1 and acc=5 → out_valid=0 and acc=0 immediately. The first ACC_ADD a=2 after release → 2.
